instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset; clears all state immediately, independent of clk.
REQ-003 start_pc  input  8  first fetch address after reset release.
REQ-004 mem_rd  output  1  RAM read strobe (combinational from state).
REQ-005 mem_addr  output  8  RAM word address; equals pc in every state.
REQ-006 mem_rdata  input  16  RAM read data, valid on the cycle after mem_rd=1 is sampled.
REQ-007 data_busy  input  1  execute stage owns RAM this cycle; fetch SHALL NOT assert mem_rd while high.
REQ-008 ir  output  16  fetched instruction word (registered).
REQ-009 ir_valid  output  1  ir holds an instruction not yet accepted downstream.
REQ-010 ir_ready  input  1  downstream accepts ir when ir_valid&ir_ready at a rising edge.
REQ-011 redirect  input  1  branch/jump: discard in-flight fetch, restart at redirect_pc.
REQ-012 redirect_pc  input  8  new fetch address when redirect=1.
REQ-013 pc  output  8  address of next word to fetch (registered).
REQ-014 halted  output  1  HALT (ir[15:13]=3'b111) accepted; fetch stopped.

Function
REQ-015 FSM states SHALL be S_RESET, S_REQ, S_WAIT, S_HOLD, S_HALT.
REQ-016 S_RESET: pc<=start_pc, next S_REQ; mem_rd=0.
REQ-017 S_REQ: data_busy=1 -> mem_rd=0, stay; data_busy=0 -> mem_rd=1, next S_WAIT.
REQ-018 S_WAIT: ir<=mem_rdata, ir_valid<=1, pc<=pc+1 (8-bit, 255 wraps to 0), next S_HOLD.
REQ-019 S_HOLD: ir, ir_valid, pc stable until ir_valid&ir_ready; no RAM access.
REQ-020 S_HOLD accept, ir[15:13]!=3'b111 -> ir_valid<=0, next S_REQ.
REQ-021 S_HOLD accept, ir[15:13]=3'b111 -> ir_valid<=0, halted<=1, next S_HALT.
REQ-022 S_HALT: mem_rd=0, ir_valid=0, halted=1; only rst_n exits.
REQ-023 redirect=1 in S_REQ/S_WAIT/S_HOLD SHALL override all other transitions: pc<=redirect_pc, ir_valid<=0, next S_REQ; S_WAIT data discarded (ir unchanged).
REQ-024 redirect with ir_ready in S_HOLD: transfer counts as accepted, HALT check suppressed, redirect wins.
REQ-025 redirect ignored in S_RESET and S_HALT.
REQ-026 Unstalled latency: mem_rd at cycle n, ir_valid=1 from cycle n+2, next mem_rd at n+3; peak 1 instruction per 3 cycles.
REQ-027 data_busy in S_WAIT/S_HOLD has no effect.

Reset
REQ-028 rst_n=0 SHALL force state=S_RESET, pc=0, ir=0, ir_valid=0, halted=0, hence mem_rd=0, mem_addr=0.
REQ-029 Reset mid-fetch SHALL abandon the access; first fetch after release uses current start_pc.

Verification
REQ-030 start_pc=28, mem[28]=16'hD064, mem[29]=16'hE000, ir_ready=1 -> reads at 28 then 29, ir=D064 then E000, halted=1, pc=30, no further mem_rd.
REQ-031 ir_ready=0 for 5 cycles in S_HOLD -> ir, ir_valid=1, pc unchanged, mem_rd=0 throughout; fetch resumes 1 cycle after ir_ready=1.
REQ-032 data_busy=1 for 3 cycles entering S_REQ at pc=40 -> mem_rd=0 those 3 cycles, mem_rd=1 with mem_addr=40 next cycle.
REQ-033 redirect=1, redirect_pc=5 during S_WAIT of addr 40 -> mem[40] never on ir, next mem_rd has mem_addr=5.
REQ-034 start_pc=255, non-HALT word -> after capture pc=0, next read mem_addr=0.
REQ-035 rst_n low during S_WAIT -> outputs reset without clock edge; after release fetch restarts at start_pc.

Source files
------------

// File: rtl/instr_fetch.sv
`timescale 1ns/1ps
// Instruction fetch unit: fetches one 16-bit word per request from a shared RAM,
// holds it for downstream, and handles redirects and HALT.
module instr_fetch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  start_pc,
  output logic        mem_rd,
  output logic [7:0]  mem_addr,
  input  logic [15:0] mem_rdata,
  input  logic        data_busy,
  output logic [15:0] ir,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        redirect,
  input  logic [7:0]  redirect_pc,
  output logic [7:0]  pc,
  output logic        halted,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  pc_nx;
  logic [15:0] ir_nx;
  logic        ir_valid_nx, halted_nx;

  // Handshake: a word transfers on any rising edge where ir_valid and ir_ready are both high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_RESET;
      pc       <= 8'd0;
      ir       <= 16'd0;
      ir_valid <= 1'b0;
      halted   <= 1'b0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      ir       <= ir_nx;
      ir_valid <= ir_valid_nx;
      halted   <= halted_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    ir_nx       = ir;
    ir_valid_nx = ir_valid;
    halted_nx   = halted;
    case (state)
      S_RESET: begin
        pc_nx    = start_pc;
        state_nx = S_REQ;
      end
      S_REQ: begin
        if (!data_busy) state_nx = S_WAIT;
      end
      S_WAIT: begin
        ir_nx       = mem_rdata;
        ir_valid_nx = 1'b1;
        pc_nx       = pc + 8'd1;
        state_nx    = S_HOLD;
      end
      S_HOLD: begin
        if (ir_ready) begin
          ir_valid_nx = 1'b0;
          if (ir[15:13] == 3'b111) begin
            halted_nx = 1'b1;
            state_nx  = S_HALT;
          end else begin
            state_nx = S_REQ;
          end
        end
      end
      S_HALT: state_nx = S_HALT;
      default: state_nx = S_RESET;
    endcase
    // A redirect wins over everything in the active states; a word in flight is dropped.
    if (redirect && (state == S_REQ || state == S_WAIT || state == S_HOLD)) begin
      pc_nx       = redirect_pc;
      ir_nx       = ir;
      ir_valid_nx = 1'b0;
      halted_nx   = halted;
      state_nx    = S_REQ;
    end
  end

  assign mem_rd    = (state == S_REQ) && !data_busy;
  assign mem_addr  = pc;
  assign fsm_state = state;

endmodule
